vga_frame_pos_ctrl: RTL and testbench
=====================================

Name: vga_frame_pos_ctrl

Overview:
- Frame-synchronous controller that feeds the five ship renderers (submarino, cruzador, hidroaviao, encouracado, porta-avioes) with their position vectors.
- Game logic writes position updates at any time through a valid/ready port into a shadow bank.
- Updated entries are committed to the live bank only at vertical-blank start, so no ship ever tears mid-frame.
- Sits between the game FSM and the VGA_* ship renderers; watches the VGA linha/coluna counters.

Parameters:
- N_SHIPS, 5, number of ship renderers / position slots
- POS_W, 64, width of one ship position vector (renderer posicoesEmbarcacao format)
- V_ACTIVE, 480, first non-visible line; vblank starts at linha == V_ACTIVE, coluna == 0
- BLINK_FRAMES, 16, frames per blink half-period (BLINK_EN only)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- linha  in  10  current VGA line
- coluna  in  10  current VGA column
- upd_valid  in  1  update request from game logic
- upd_ready  out  1  controller can accept an update
- upd_id  in  3  target slot, 0..N_SHIPS-1
- upd_pos  in  POS_W  new position vector
- pos_out  out  N_SHIPS*POS_W  live position bank; slot i at [i*POS_W +: POS_W]
- frame_committed  out  1  one-cycle pulse when a commit completes
- upd_err  out  1  sticky flag: an update with upd_id >= N_SHIPS was accepted
- hit_mask  in  N_SHIPS  ships to highlight (used only with BLINK_EN)
- vis_mask  out  N_SHIPS  per-ship visibility gate for the renderers

Behaviour:
- Reset (async, rst_n low): shadow and live banks = 0 (all coordinates 0 means no ship drawn); dirty = 0; state IDLE; upd_ready = 0 while rst_n low, 1 from the first clk after release; frame_committed = 0; upd_err = 0; vis_mask = all 1s.
- Handshake: transfer occurs when upd_valid && upd_ready at a rising edge.
  - The shadow slot upd_id is written and dirty[upd_id] is set.
  - A later write to the same slot before commit overwrites it (last write wins).
  - upd_id >= N_SHIPS: transfer is accepted, data is dropped, upd_err is set (cleared only by reset).
- vblank_start: registered one-cycle pulse, generated on the cycle after linha == V_ACTIVE && coluna == 0 is sampled.
- FSM:
  - IDLE: upd_ready = 1. On vblank_start with dirty != 0, go to COMMIT with idx = 0. On vblank_start with dirty == 0, stay in IDLE; no pulse.
  - COMMIT: upd_ready = 0. Each cycle, if dirty[idx], copy shadow[idx] to live[idx] and clear dirty[idx]; then idx++. After idx == N_SHIPS-1, go to DONE. Takes exactly N_SHIPS cycles.
  - DONE: upd_ready = 0 for one cycle, frame_committed = 1, then return to IDLE.
- Latency: an update accepted no later than the vblank_start cycle appears on pos_out between 1 and N_SHIPS cycles after vblank_start, and always before the next visible line. An update accepted later is held for the next frame.
- A slot that is not dirty keeps its live value unchanged.
- Simultaneous events:
  - Update accepted on the vblank_start cycle is included in that commit.
  - vblank_start while in COMMIT or DONE cannot occur, since each frame has one pulse; if it does, it is ignored.
- Reset mid-COMMIT: all state is discarded, both banks return to 0, no frame_committed pulse.
- pos_out is purely registered; no combinational path from upd_* to pos_out.

Optional Feature:
- Macro: VGA_FRAME_POS_BLINK_EN
- Enabled:
  - Frame counter increments on each vblank_start and wraps at BLINK_FRAMES-1.
  - blink_phase toggles on each wrap; blink_phase resets to 1.
  - vis_mask[i] = ~hit_mask[i] | blink_phase, registered and updated on vblank_start only.
- Disabled: vis_mask is tied to all 1s, hit_mask is ignored, and no frame counter is built.

Decomposition:
- Shared package vga_bn_pkg holds:
  - N_SHIPS and POS_W
  - Ship id constants: SHIP_SUBMARINO = 0, SHIP_CRUZADOR = 1, SHIP_HIDROAVIAO = 2, SHIP_ENCOURACADO = 3, SHIP_PORTA_AVIOES = 4
  - V_ACTIVE
  - FSM state type (IDLE, COMMIT, DONE)
- Sub-module vga_frame_sync: vblank_start detector plus the optional blink frame counter. It is reused by the future cursor and shot-marker blocks.

Test Plan:
- Reset release, no updates, run 3 frames -> pos_out = 0; frame_committed never pulses; upd_ready = 1 from the first clk.
- Write slot 2 = 0x0000_0000_0000_0484 mid-frame (linha = 100) -> pos_out slot 2 unchanged until vblank_start; equals 0x...0484 within 5 cycles after it; single frame_committed pulse.
- Write slot 0 twice (0x111, then 0x222) before vblank -> live slot 0 = 0x222; other slots unchanged.
- Update presented with upd_valid held during COMMIT -> upd_ready = 0 for 6 cycles (5 COMMIT + 1 DONE); transfer completes in IDLE; data appears at the next frame's commit, not the current one.
- upd_id = 6 accepted -> upd_err = 1 and stays 1; no slot changes; dirty stays 0, so no commit pulse.
- BLINK_EN, BLINK_FRAMES = 2, hit_mask = 5'b00100 -> vis_mask[2] toggles every 2 frames (1,1,0,0,1,...); other bits stay 1.
- Reset asserted during COMMIT -> pos_out = 0 immediately; no frame_committed pulse.

Source files
------------

// File: rtl/vga_bn_pkg.sv
// Shared constants and types for the VGA battleship display blocks.
package vga_bn_pkg;

  localparam int N_SHIPS  = 5;
  localparam int POS_W    = 64;
  localparam int V_ACTIVE = 480;

  localparam int SHIP_SUBMARINO     = 0;
  localparam int SHIP_CRUZADOR      = 1;
  localparam int SHIP_HIDROAVIAO    = 2;
  localparam int SHIP_ENCOURACADO   = 3;
  localparam int SHIP_PORTA_AVIOES  = 4;

  typedef enum logic [1:0] {
    IDLE,
    COMMIT,
    DONE
  } state_t;

endpackage

// File: rtl/vga_frame_sync.sv
// Vertical-blank start detector plus the optional blink frame counter.
// Blink logic is built only when VGA_FRAME_POS_BLINK_EN is defined.
module vga_frame_sync
  import vga_bn_pkg::*;
#(
  parameter int BLINK_FRAMES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [9:0]         i_linha,
  input  logic [9:0]         i_coluna,
  input  logic [N_SHIPS-1:0] i_hit_mask,
  output logic               o_vblank_start,
  output logic [N_SHIPS-1:0] o_vis_mask
);

  logic r_vblank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vblank <= 1'b0;
    end else begin
      r_vblank <= (i_linha == 10'(V_ACTIVE)) && (i_coluna == 10'd0);
    end
  end

  assign o_vblank_start = r_vblank;

`ifdef VGA_FRAME_POS_BLINK_EN
  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0]      r_frame_cnt;
  logic               r_blink_phase;
  logic [N_SHIPS-1:0] r_vis;

  // The mask for a frame uses the phase in force before this vblank's wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b1;
      r_vis         <= '1;
    end else if (r_vblank) begin
      r_vis <= ~i_hit_mask | {N_SHIPS{r_blink_phase}};
      if (r_frame_cnt == CW'(BLINK_FRAMES - 1)) begin
        r_frame_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign o_vis_mask = r_vis;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (^i_hit_mask) ^ (BLINK_FRAMES > 0);
  assign o_vis_mask   = '1;
`endif

endmodule

// File: rtl/vga_frame_pos_ctrl.sv
// Double-buffered ship position bank, committed to the renderers at vblank start.
// Optional blink gating via VGA_FRAME_POS_BLINK_EN (see vga_frame_sync).
module vga_frame_pos_ctrl
  import vga_bn_pkg::*;
#(
  parameter int BLINK_FRAMES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [9:0]               linha,
  input  logic [9:0]               coluna,
  input  logic                     upd_valid,
  output logic                     upd_ready,
  input  logic [2:0]               upd_id,
  input  logic [POS_W-1:0]         upd_pos,
  output logic [N_SHIPS*POS_W-1:0] pos_out,
  output logic                     frame_committed,
  output logic                     upd_err,
  input  logic [N_SHIPS-1:0]       hit_mask,
  output logic [N_SHIPS-1:0]       vis_mask
);

  state_t                          r_state;
  logic [2:0]                      r_idx;
  logic [N_SHIPS-1:0]              r_dirty;
  logic [N_SHIPS-1:0][POS_W-1:0]   r_shadow;
  logic [N_SHIPS-1:0][POS_W-1:0]   r_live;
  logic                            r_ready;
  logic                            r_committed;
  logic                            r_err;

  logic                            w_vblank;
  logic                            w_xfer;
  logic                            w_id_ok;
  logic [N_SHIPS-1:0]              w_set;

  vga_frame_sync #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_sync (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_linha        (linha),
    .i_coluna       (coluna),
    .i_hit_mask     (hit_mask),
    .o_vblank_start (w_vblank),
    .o_vis_mask     (vis_mask)
  );

  assign w_xfer  = upd_valid && r_ready;
  assign w_id_ok = upd_id < 3'(N_SHIPS);

  always_comb begin
    w_set = '0;
    if (w_xfer && w_id_ok) begin
      w_set[upd_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else begin
      for (int i = 0; i < N_SHIPS; i++) begin
        if (w_set[i]) begin
          r_shadow[i] <= upd_pos;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_xfer && !w_id_ok) begin
      r_err <= 1'b1;
    end
  end

  // A write landing on the vblank cycle is folded into the dirty check so it
  // joins this frame's commit; the shadow copy is readable by the first COMMIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_dirty     <= '0;
      r_live      <= '0;
      r_ready     <= 1'b0;
      r_committed <= 1'b0;
    end else begin
      r_committed <= 1'b0;
      case (r_state)
        IDLE: begin
          r_dirty <= r_dirty | w_set;
          if (w_vblank && ((r_dirty | w_set) != '0)) begin
            r_state <= COMMIT;
            r_idx   <= '0;
            r_ready <= 1'b0;
          end else begin
            r_ready <= 1'b1;
          end
        end
        COMMIT: begin
          if (r_dirty[r_idx]) begin
            r_live[r_idx]  <= r_shadow[r_idx];
            r_dirty[r_idx] <= 1'b0;
          end
          if (r_idx == 3'(N_SHIPS - 1)) begin
            r_state     <= DONE;
            r_committed <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign pos_out         = r_live;
  assign upd_ready       = r_ready;
  assign frame_committed = r_committed;
  assign upd_err         = r_err;

endmodule

// File: tb/tb_vga_frame_pos_ctrl.sv
// Self-checking bench for vga_frame_pos_ctrl: table vectors, corner sequences
// and random frames checked against a frame-level model of the position banks.
`timescale 1ns/1ps
module tb_vga_frame_pos_ctrl;
  import vga_bn_pkg::*;

  localparam int BF = 2;
  localparam int BW = N_SHIPS * POS_W;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [9:0]         linha;
  logic [9:0]         coluna;
  logic               upd_valid;
  logic               upd_ready;
  logic [2:0]         upd_id;
  logic [POS_W-1:0]   upd_pos;
  logic [BW-1:0]      pos_out;
  logic               frame_committed;
  logic               upd_err;
  logic [N_SHIPS-1:0] hit_mask;
  logic [N_SHIPS-1:0] vis_mask;

  vga_frame_pos_ctrl #(.BLINK_FRAMES(BF)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .linha           (linha),
    .coluna          (coluna),
    .upd_valid       (upd_valid),
    .upd_ready       (upd_ready),
    .upd_id          (upd_id),
    .upd_pos         (upd_pos),
    .pos_out         (pos_out),
    .frame_committed (frame_committed),
    .upd_err         (upd_err),
    .hit_mask        (hit_mask),
    .vis_mask        (vis_mask)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nErr = 0;

  // Frame-level model: shadow writes, pending set, live bank, sticky error.
  logic [POS_W-1:0]   mShadow [N_SHIPS];
  logic [POS_W-1:0]   mLive   [N_SHIPS];
  logic [N_SHIPS-1:0] mPend;
  logic               mErr;
  int                 nFrames;

  typedef struct {
    logic [2:0]       id;
    logic [POS_W-1:0] pos;
    int               expPulses;
    logic             expErr;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < N_SHIPS; i++) begin
      mShadow[i] = '0;
      mLive[i]   = '0;
    end
    mPend   = '0;
    mErr    = 1'b0;
    nFrames = 0;
  endtask

  task automatic modelCommit();
    for (int i = 0; i < N_SHIPS; i++) begin
      if (mPend[i]) mLive[i] = mShadow[i];
    end
    mPend = '0;
  endtask

  function automatic logic [BW-1:0] modelBank();
    logic [BW-1:0] b;
    for (int i = 0; i < N_SHIPS; i++) b[i*POS_W +: POS_W] = mLive[i];
    return b;
  endfunction

  function automatic logic [N_SHIPS-1:0] expVis();
`ifdef VGA_FRAME_POS_BLINK_EN
    logic phase;
    phase = (((nFrames - 1) / BF) % 2) == 0;
    return ~hit_mask | {N_SHIPS{phase}};
`else
    return '1;
`endif
  endfunction

  task automatic applyStimulus(input logic [2:0] id, input logic [POS_W-1:0] pos);
    checkOutput("ready_before_write", upd_ready, 1);
    upd_valid = 1'b1;
    upd_id    = id;
    upd_pos   = pos;
    tick();
    upd_valid = 1'b0;
    if (id < 3'(N_SHIPS)) begin
      mShadow[id] = pos;
      mPend[id]   = 1'b1;
    end else begin
      mErr = 1'b1;
    end
  endtask

  task automatic midFrame(input int n);
    linha  = 10'd100;
    coluna = 10'd200;
    repeat (n) tick();
  endtask

  // One vblank plus a settling window; checks the frame against the model.
  task automatic commitAndCheck(input int watchSlot, input logic [POS_W-1:0] watchVal,
                                output int seenAt, output int pulses);
    int lowCnt;
    int expPulses;
    expPulses = (mPend != '0) ? 1 : 0;
    linha  = 10'(V_ACTIVE);
    coluna = 10'd0;
    tick();
    linha  = 10'(V_ACTIVE + 1);
    coluna = 10'd5;
    pulses = 0;
    lowCnt = 0;
    seenAt = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (frame_committed) pulses++;
      if (!upd_ready) lowCnt++;
      if (watchSlot >= 0 && seenAt < 0 && pos_out[watchSlot*POS_W +: POS_W] === watchVal) seenAt = k;
    end
    nFrames++;
    modelCommit();
    checkOutput("commit_pulses", pulses, expPulses);
    checkOutput("ready_low_cycles", lowCnt, expPulses * (N_SHIPS + 1));
    checkOutput("live_bank", pos_out, modelBank());
    checkOutput("upd_err", upd_err, mErr);
    checkOutput("vis_mask", vis_mask, expVis());
    linha  = 10'd0;
    coluna = 10'd0;
  endtask

  initial begin
    int seenAt;
    int pulses;
    int lowCnt;
    int nW;
    logic [2:0] rid;
    logic [POS_W-1:0] rpos;
    logic [4:0] blinkSeq;

    vecs[0] = '{3'd2, 64'h0000_0000_0000_0484, 1, 1'b0};
    vecs[1] = '{3'd4, 64'hDEAD_BEEF_0123_4567, 1, 1'b0};
    vecs[2] = '{3'd0, 64'h0000_0001_0002_0003, 1, 1'b0};
    vecs[3] = '{3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0};
    vecs[4] = '{3'd6, 64'h0000_0000_0000_1234, 0, 1'b1};
    vecs[5] = '{3'd1, 64'h0000_0000_0000_0A0B, 1, 1'b1};

    rst_n     = 1'b0;
    linha     = 10'd0;
    coluna    = 10'd0;
    upd_valid = 1'b0;
    upd_id    = 3'd0;
    upd_pos   = '0;
    hit_mask  = '0;
    modelReset();

    repeat (3) tick();
    checkOutput("reset_pos_out", pos_out, '0);
    checkOutput("reset_ready", upd_ready, 0);
    checkOutput("reset_committed", frame_committed, 0);
    checkOutput("reset_err", upd_err, 0);
    checkOutput("reset_vis", vis_mask, {N_SHIPS{1'b1}});

    rst_n = 1'b1;
    tick();
    checkOutput("ready_first_clk", upd_ready, 1);

    for (int f = 0; f < 3; f++) begin
      midFrame(4);
      commitAndCheck(-1, '0, seenAt, pulses);
    end

    for (int v = 0; v < 6; v++) begin
      midFrame(1);
      applyStimulus(vecs[v].id, vecs[v].pos);
      midFrame(3);
      checkOutput("no_tear_before_vblank", pos_out, modelBank());
      commitAndCheck((vecs[v].id < 3'(N_SHIPS)) ? int'(vecs[v].id) : -1, vecs[v].pos, seenAt, pulses);
      checkOutput("vec_pulses", pulses, vecs[v].expPulses);
      checkOutput("vec_err", upd_err, vecs[v].expErr);
      if (vecs[v].id < 3'(N_SHIPS)) begin
        checkOutput("vec_slot", pos_out[int'(vecs[v].id)*POS_W +: POS_W], vecs[v].pos);
        checkOutput("vec_latency", (seenAt >= 2 && seenAt <= N_SHIPS + 1) ? 1 : 0, 1);
      end
    end

    midFrame(1);
    applyStimulus(3'd0, 64'h111);
    applyStimulus(3'd0, 64'h222);
    midFrame(2);
    commitAndCheck(0, 64'h222, seenAt, pulses);
    checkOutput("last_write_wins", pos_out[0 +: POS_W], 64'h222);
    checkOutput("double_write_pulse", pulses, 1);

    // Valid raised while COMMIT is running must wait for IDLE and the next frame.
    midFrame(1);
    applyStimulus(3'd1, 64'hAAAA_5555_AAAA_5555);
    linha  = 10'(V_ACTIVE);
    coluna = 10'd0;
    tick();
    linha  = 10'(V_ACTIVE + 1);
    coluna = 10'd5;
    tick();
    lowCnt = 0;
    pulses = 0;
    if (!upd_ready) lowCnt++;
    if (frame_committed) pulses++;
    upd_valid = 1'b1;
    upd_id    = 3'd3;
    upd_pos   = 64'h3333;
    for (int k = 2; k <= 7; k++) begin
      tick();
      if (!upd_ready) lowCnt++;
      if (frame_committed) pulses++;
    end
    tick();
    upd_valid = 1'b0;
    nFrames++;
    modelCommit();
    mShadow[3] = 64'h3333;
    mPend[3]   = 1'b1;
    checkOutput("hold_ready_low", lowCnt, N_SHIPS + 1);
    checkOutput("hold_pulse", pulses, 1);
    checkOutput("hold_bank", pos_out, modelBank());
    midFrame(2);
    commitAndCheck(3, 64'h3333, seenAt, pulses);
    checkOutput("hold_next_frame", pos_out[3*POS_W +: POS_W], 64'h3333);

    // Reset landing in the middle of a commit.
    midFrame(1);
    applyStimulus(3'd4, 64'h4444_0000_4444_0000);
    linha  = 10'(V_ACTIVE);
    coluna = 10'd0;
    tick();
    linha  = 10'(V_ACTIVE + 1);
    coluna = 10'd5;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midcommit_reset_pos", pos_out, '0);
    checkOutput("midcommit_reset_pulse", frame_committed, 0);
    checkOutput("midcommit_reset_err", upd_err, 0);
    modelReset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("ready_after_rereset", upd_ready, 1);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (frame_committed) pulses++;
    end
    checkOutput("no_pulse_after_reset", pulses, 0);

`ifdef VGA_FRAME_POS_BLINK_EN
    blinkSeq = 5'b10011;
`else
    blinkSeq = 5'b11111;
`endif
    hit_mask = 5'b00100;
    for (int f = 0; f < 5; f++) begin
      midFrame(3);
      commitAndCheck(-1, '0, seenAt, pulses);
      checkOutput("blink_vis2", vis_mask[2], blinkSeq[f]);
      checkOutput("blink_others", vis_mask & 5'b11011, 5'b11011);
    end

    for (int f = 0; f < 20; f++) begin
      hit_mask = N_SHIPS'($urandom);
      midFrame(2);
      nW = $urandom_range(0, 4);
      for (int w = 0; w < nW; w++) begin
        rid  = 3'($urandom_range(0, N_SHIPS));
        rpos = {$urandom, $urandom};
        applyStimulus(rid, rpos);
      end
      midFrame(2);
      checkOutput("rand_no_tear", pos_out, modelBank());
      commitAndCheck(-1, '0, seenAt, pulses);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
